// File: rtl/btn_jk_encoder_pkg.sv
// btn_jk_encoder_pkg: shared types for the push-button J/K encoder.
// Gesture states, {J,K} command codes and counter sizing.
package btn_jk_encoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_GAP    = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_HELD   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CMD_HOLD   = 2'b00,
    CMD_CLEAR  = 2'b01,
    CMD_SET    = 2'b10,
    CMD_TOGGLE = 2'b11
  } cmd_t;

  function automatic int cnt_bits(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_jk_encoder_if.sv
// btn_jk_if: raw button in, J/K command and debounced level out.
// slave is the encoder side, master is the button/consumer side.
interface btn_jk_if;

  logic Btn;
  logic J;
  logic K;
  logic Pressed;

  modport master (
    output Btn,
    input  J,
    input  K,
    input  Pressed
  );

  modport slave (
    input  Btn,
    output J,
    output K,
    output Pressed
  );

endinterface

// File: rtl/btn_jk_encoder_debouncer.sv
// btn_debouncer: two-flop synchroniser plus a stability counter
// that moves Pressed only after DEBOUNCE_CYCLES agreeing samples.
module btn_debouncer
  import btn_jk_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Btn,
  output logic Pressed
);

  localparam int W = cnt_bits(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);

  logic         s1;
  logic         s2;
  logic [W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      cnt     <= '0;
      Pressed <= 1'b0;
    end else begin
      s1 <= Btn;
      s2 <= s1;
      if (s2 == Pressed) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt     <= '0;
        Pressed <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_jk_encoder.sv
// btn_jk_encoder: classifies debounced presses into single, double
// and long gestures and emits one-cycle TOGGLE/SET/CLEAR J/K pulses.
module btn_jk_encoder
  import btn_jk_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 16,
  parameter int GAP_CYCLES      = 8
) (
  input logic     Clk,
  input logic     Reset,
  btn_jk_if.slave bus
);

  localparam int HW = cnt_bits(LONG_CYCLES);
  localparam int GW = cnt_bits(GAP_CYCLES);

  // Counts start at 0 one edge after Pressed moves and are compared
  // before incrementing, so the deciding value is param - 2.
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 2);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 2);

  logic          pressed;
  state_t        state;
  state_t        state_n;
  logic [HW-1:0] hold;
  logic [HW-1:0] hold_n;
  logic [GW-1:0] gap;
  logic [GW-1:0] gap_n;
  cmd_t          cmd;
  cmd_t          cmd_n;

  btn_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb (
    .Clk     (Clk),
    .Reset   (Reset),
    .Btn     (bus.Btn),
    .Pressed (pressed)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      hold  <= '0;
      gap   <= '0;
      cmd   <= CMD_HOLD;
    end else begin
      state <= state_n;
      hold  <= hold_n;
      gap   <= gap_n;
      cmd   <= cmd_n;
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold;
    gap_n   = gap;
    cmd_n   = CMD_HOLD;
    unique case (state)
      ST_IDLE: begin
        if (pressed) begin
          state_n = ST_PRESS1;
          hold_n  = '0;
        end
      end
      ST_PRESS1,
      ST_PRESS2: begin
        // long is decided before release so a tie still clears
        if (hold == HOLD_LAST) begin
          state_n = ST_HELD;
          cmd_n   = CMD_CLEAR;
        end else if (!pressed) begin
          if (state == ST_PRESS1) begin
            state_n = ST_GAP;
            gap_n   = '0;
          end else begin
            state_n = ST_IDLE;
            cmd_n   = CMD_SET;
          end
        end else begin
          hold_n = hold + 1'b1;
        end
      end
      ST_GAP: begin
        if (pressed) begin
          state_n = ST_PRESS2;
          hold_n  = '0;
        end else if (gap == GAP_LAST) begin
          state_n = ST_IDLE;
          cmd_n   = CMD_TOGGLE;
        end else begin
          gap_n = gap + 1'b1;
        end
      end
      ST_HELD: begin
        if (!pressed) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign bus.J       = cmd[1];
  assign bus.K       = cmd[0];
  assign bus.Pressed = pressed;

  a_single_pulse: assert property (
    @(posedge Clk) disable iff (Reset)
    (cmd != CMD_HOLD) |=> (cmd == CMD_HOLD)
  );

endmodule

// File: tb/tb_btn_jk_encoder.sv
// tb_btn_jk_encoder: directed gestures plus random button traffic
// against a timestamp-based reference model of the encoder.
module tb_btn_jk_encoder;

  localparam int DEB  = 4;
  localparam int LONG = 16;
  localparam int GAP  = 8;

  localparam logic [1:0] C_HOLD = 2'b00;
  localparam logic [1:0] C_CLR  = 2'b01;
  localparam logic [1:0] C_SET  = 2'b10;
  localparam logic [1:0] C_TGL  = 2'b11;

  logic clk = 1'b0;
  logic reset;
  logic q = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  btn_jk_if bus();

  btn_jk_encoder #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG),
    .GAP_CYCLES      (GAP)
  ) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // downstream JK flip-flop driven by the DUT
  always @(posedge clk) begin
    case ({bus.J, bus.K})
      2'b10:   q <= 1'b1;
      2'b01:   q <= 1'b0;
      2'b11:   q <= ~q;
      default: q <= q;
    endcase
  end

  // reference model
  int         t = 0;
  logic       smp[$];
  logic       m_pressed = 1'b0;
  logic       m_q = 1'b0;
  logic [1:0] m_cmd = 2'b00;
  int         phase = 0;
  int         t_rise = 0;
  int         t_fall = 0;

  // scenario bookkeeping
  int         npulse;
  logic [1:0] last_code;
  logic       pressed_seen;
  logic       prev_nz = 1'b0;

  function automatic logic s2_ago(input int k);
    int idx;
    idx = smp.size() - 2 - k;
    return (idx >= 0) ? smp[idx] : 1'b0;
  endfunction

  task automatic model_step(input logic b, input logic r);
    logic       p;
    logic       flip;
    logic [1:0] nc;
    t++;
    case (m_cmd)
      C_SET:   m_q = 1'b1;
      C_CLR:   m_q = 1'b0;
      C_TGL:   m_q = ~m_q;
      default: m_q = m_q;
    endcase
    if (r) begin
      smp.delete();
      m_pressed = 1'b0;
      m_cmd = C_HOLD;
      phase = 0;
      return;
    end
    p = m_pressed;
    nc = C_HOLD;
    case (phase)
      0: if (p) phase = 1;
      1, 3: begin
        if (t - t_rise >= LONG) begin
          nc = C_CLR;
          phase = 4;
        end else if (!p) begin
          if (phase == 1) phase = 2;
          else begin
            nc = C_SET;
            phase = 0;
          end
        end
      end
      2: begin
        if (p) phase = 3;
        else if (t - t_fall >= GAP) begin
          nc = C_TGL;
          phase = 0;
        end
      end
      default: if (!p) phase = 0;
    endcase
    flip = 1'b1;
    for (int k = 0; k < DEB; k++)
      if (s2_ago(k) == m_pressed) flip = 1'b0;
    if (flip) begin
      m_pressed = ~m_pressed;
      if (m_pressed) t_rise = t;
      else t_fall = t;
    end
    smp.push_back(b);
    m_cmd = nc;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0d",
               tag, got, exp, t);
    end
  endtask

  task automatic tick(input logic b, input logic r);
    logic [1:0] jk;
    bus.Btn = b;
    reset = r;
    @(posedge clk);
    model_step(b, r);
    @(negedge clk);
    jk = {bus.J, bus.K};
    check("pressed", {31'd0, bus.Pressed}, {31'd0, m_pressed});
    check("jk", {30'd0, jk}, {30'd0, m_cmd});
    check("q", {31'd0, q}, {31'd0, m_q});
    check("b2b", {31'd0, prev_nz && (jk != C_HOLD)}, 32'd0);
    prev_nz = (jk != C_HOLD);
    if (jk != C_HOLD) begin
      npulse++;
      last_code = jk;
    end
    if (bus.Pressed) pressed_seen = 1'b1;
  endtask

  task automatic press(input int hi, input int lo);
    repeat (hi) tick(1'b1, 1'b0);
    repeat (lo) tick(1'b0, 1'b0);
  endtask

  task automatic scen_start();
    npulse = 0;
    last_code = C_HOLD;
    pressed_seen = 1'b0;
  endtask

  task automatic scen_end(input string tag, input int exp_n,
                          input logic [1:0] exp_code, input logic exp_q);
    check({tag, "_pulses"}, npulse, exp_n);
    if (exp_n > 0) check({tag, "_code"}, {30'd0, last_code}, {30'd0, exp_code});
    check({tag, "_qend"}, {31'd0, q}, {31'd0, exp_q});
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    bus.Btn = 1'b0;
    @(negedge clk);

    // reset held with button down, then latency of the fresh press
    scen_start();
    repeat (2) tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b1, 1'b0);
      if (bus.Pressed && lat < 0) lat = i;
    end
    check("rst_lat", lat, 5);
    repeat (10) tick(1'b1, 1'b0);
    repeat (30) tick(1'b0, 1'b0);
    scen_end("rst_long", 1, C_CLR, 1'b0);

    scen_start();
    press(3, 20);
    check("glitch_pressed", {31'd0, pressed_seen}, 32'd0);
    scen_end("glitch", 0, C_HOLD, 1'b0);

    scen_start();
    press(8, 20);
    scen_end("single", 1, C_TGL, 1'b1);

    scen_start();
    press(30, 20);
    scen_end("long", 1, C_CLR, 1'b0);

    scen_start();
    press(6, 4);
    press(6, 20);
    scen_end("double", 1, C_SET, 1'b1);

    scen_start();
    press(15, 25);
    scen_end("long_tie", 1, C_CLR, 1'b0);

    scen_start();
    press(6, 7);
    press(6, 20);
    scen_end("gap_tie", 1, C_SET, 1'b1);

    scen_start();
    press(8, 10);
    tick(1'b0, 1'b1);
    repeat (20) tick(1'b0, 1'b0);
    scen_end("rst_gap", 0, C_HOLD, 1'b1);

    scen_start();
    press(8, 20);
    scen_end("after_rst", 1, C_TGL, 1'b0);

    for (int g = 0; g < 60; g++) begin
      if ($urandom_range(0, 7) == 0) tick(1'b0, 1'b1);
      press($urandom_range(1, 36), $urandom_range(1, 26));
    end
    repeat (40) tick(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
